counter_strobe_multi_pipeline: RTL

Multi-channel, pipelined-carry down-counter strobe generator. Each of `CHANNELS` independent channels counts enabled clock cycles against its own programmable period. Each channel emits a one-cycle `strobe` on the period's last enabled cycle, in either periodic (auto-reload) or one-shot mode. It is the parametrised successor to the single-channel pipelined strobe counter. It sits under baud, tick and timeout generators that need several rates from one clock.

---
 rtl/counter_strobe_multi_pipeline_if.sv | 22 ++
 rtl/counter_strobe_multi_pipeline.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/counter_strobe_multi_pipeline_if.sv
// Bus bundle for counter_strobe_multi_pipeline: per-channel controls in, strobes and status out.
// Optional feature macro: COUNTER_STROBE_TALLY_EN adds the per-channel 8-bit strobe tally.
interface counter_strobe_multi_pipeline_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS*WIDTH-1:0] reset_value;
    logic [CHANNELS-1:0]       strobe;
    logic [CHANNELS-1:0]       busy;
`ifdef COUNTER_STROBE_TALLY_EN
    logic [CHANNELS*8-1:0]     tally;

    modport master (output enable, load, mode, reset_value, input strobe, busy, tally);
    modport slave  (input enable, load, mode, reset_value, output strobe, busy, tally);
`else
    modport master (output enable, load, mode, reset_value, input strobe, busy);
    modport slave  (input enable, load, mode, reset_value, output strobe, busy);
`endif
endinterface

// File: rtl/counter_strobe_multi_pipeline.sv
// Multi-channel down-counter strobe generator with a chunked, pipelined-borrow counter per channel.
// Each channel strobes on the N-th enabled cycle after a load, periodically or once.
// Optional feature macro: COUNTER_STROBE_TALLY_EN adds a saturating 8-bit strobe tally per channel.
module counter_strobe_multi_pipeline #(
    parameter int WIDTH    = 16,
    parameter int LUT_SIZE = 4,
    parameter int CHANNELS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    counter_strobe_multi_pipeline_if.slave bus
);
    localparam int NCHUNK = (WIDTH + LUT_SIZE - 1) / LUT_SIZE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [CHANNELS-1:0]   w_strobe;
    logic [CHANNELS-1:0]   w_busy;
`ifdef COUNTER_STROBE_TALLY_EN
    logic [CHANNELS*8-1:0] w_tally;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]        r_state;
        logic [WIDTH-1:0]  r_period;
        logic              r_oneshot;
        logic [WIDTH-1:0]  w_in;
        logic [WIDTH-1:0]  w_src;
        logic              w_load;
        logic              w_run;
        logic              w_c0_one;
        logic              w_prefire;
        logic              w_fire;
        logic              w_reload;
        logic              w_restart;
        // Decrement request into each chunk: bit 0 is the counted cycle, bit k is the borrow out of chunk k-1.
        logic [NCHUNK-1:0] w_bin;
        // Registered "chunk is zero" flags; chunk 0 is compared directly so its bit is tied high.
        logic [NCHUNK-1:0] w_zero;

        assign w_in      = bus.reset_value[c*WIDTH +: WIDTH];
        assign w_load    = rst | bus.load[c];
        assign w_run     = (r_state == ST_RUN);
        assign w_prefire = w_run & w_c0_one & (&w_zero);
        assign w_fire    = w_prefire & bus.enable[c] & ~rst;
        assign w_reload  = w_fire & ~r_oneshot;
        assign w_restart = w_load | w_reload;
        assign w_src     = w_load ? w_in : r_period;
        assign w_bin[0]  = w_run & bus.enable[c];

        // Capture period and mode on rst/load; a one-shot parks in DONE after its strobe.
        // NOTE: rst is simply a load of every channel, so period and mode take the input values rather than a fixed constant.
        always_ff @(posedge clk) begin
            if (rst || bus.load[c]) begin
                r_period  <= w_in;
                r_oneshot <= bus.mode[c];
                r_state   <= (w_in != '0) ? ST_RUN : ST_IDLE;
            end else if (w_fire && r_oneshot) begin
                r_state   <= ST_DONE;
            end
        end

        for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
            localparam int LO = k * LUT_SIZE;
            localparam int CW = (k == NCHUNK - 1) ? (WIDTH - LO) : LUT_SIZE;

            logic [CW-1:0] r_chunk;

            // Reload the chunk from the new or stored period, otherwise step it down on request.
            // NOTE: sequential state uses non-blocking assignments so every chunk sees the pre-edge values of its neighbours.
            always_ff @(posedge clk) begin
                if (w_restart) begin
                    r_chunk <= w_src[LO +: CW];
                end else if (w_bin[k]) begin
                    r_chunk <= r_chunk - CW'(1);
                end
            end

            if (k == 0) begin : g_low
                assign w_c0_one  = (r_chunk == CW'(1));
                assign w_zero[0] = 1'b1;
            end else begin : g_high
                logic r_zero;

                // Keep the zero flag aligned with the value the chunk holds after this edge.
                always_ff @(posedge clk) begin
                    if (w_restart) begin
                        r_zero <= (w_src[LO +: CW] == '0);
                    end else if (w_bin[k]) begin
                        r_zero <= (r_chunk == CW'(1));
                    end
                end

                assign w_zero[k] = r_zero;
            end

            if (k < NCHUNK - 1) begin : g_borrow
                logic r_bout;

                // Register the borrow so the next chunk decrements one cycle later.
                always_ff @(posedge clk) begin
                    if (w_restart) begin
                        r_bout <= 1'b0;
                    end else begin
                        r_bout <= w_bin[k] & (r_chunk == '0);
                    end
                end

                assign w_bin[k+1] = r_bout;
            end
        end

        assign w_strobe[c] = w_fire;
        assign w_busy[c]   = w_run & ~rst;

`ifdef COUNTER_STROBE_TALLY_EN
        logic [7:0] r_tally;

        // Count emitted strobes, saturating at 255; a load clears first, then counts a coincident strobe.
        always_ff @(posedge clk) begin
            if (w_load) begin
                r_tally <= {7'd0, w_fire};
            end else if (w_fire && (r_tally != 8'hFF)) begin
                r_tally <= r_tally + 8'd1;
            end
        end

        assign w_tally[c*8 +: 8] = rst ? 8'd0 : r_tally;
`endif
    end

    assign bus.strobe = w_strobe;
    assign bus.busy   = w_busy;
`ifdef COUNTER_STROBE_TALLY_EN
    assign bus.tally  = w_tally;
`endif

endmodule
